// File: rtl/multi_frame_aligner.sv
// multi_frame_aligner: merges N_CH valid/ready streams into framed beats with ch0 reference capture/replay; MULTI_FRAME_ALIGNER_STATS_EN adds frame/stall stats
module multi_frame_aligner #(
  parameter int WIDTH = 32,
  parameter int N_CH = 2,
  parameter int FRAME_LEN = 128
) (
  input  logic                    in_destination_clock,
  input  logic                    reset_counter,
  input  logic [N_CH-1:0]         in_ch_valid,
  input  logic [N_CH*WIDTH-1:0]   in_ch_data,
  output logic [N_CH-1:0]         ou_ch_ready,
  input  logic                    in_capture_req,
  input  logic                    in_release_req,
  input  logic                    in_frame_ready,
  output logic                    ou_frame_valid,
  output logic                    ou_frame_last,
  output logic [N_CH*WIDTH-1:0]   ou_frame_data,
  output logic                    ou_ref_loaded
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
  ,
  output logic [15:0]             ou_frames_done,
  output logic [0:0]              ou_stall
`endif
);
  localparam int CW = $clog2(FRAME_LEN);
  typedef enum logic [1:0] {LIVE, CAPTURE, REPLAY} state_t;
  state_t state, state_n;
  logic [CW-1:0] beat_cnt, rd_addr;
  logic [N_CH-1:0] eff_valid;
  logic replay, hs, fb;
  logic [WIDTH-1:0] mem [FRAME_LEN];
  logic [WIDTH-1:0] rep_data;
  assign replay = state == REPLAY;
  assign ou_ref_loaded = replay;
  assign ou_frame_valid = &eff_valid;
  assign hs = ou_frame_valid & in_frame_ready;
  assign ou_frame_last = beat_cnt == CW'(FRAME_LEN - 1);
  assign fb = beat_cnt == '0;
  assign rd_addr = ou_frame_last ? '0 : beat_cnt + 1'b1;
  // ch0 is treated as always valid while the cache stands in for it
  always_comb begin
    eff_valid = in_ch_valid;
    eff_valid[0] = in_ch_valid[0] | replay;
    ou_ch_ready = '0;
    for (int i = 0; i < N_CH; i++) ou_ch_ready[i] = in_frame_ready & (&(eff_valid | (N_CH'(1) << i)));
    ou_ch_ready[0] = ou_ch_ready[0] & ~replay;
    ou_frame_data = in_ch_data;
    ou_frame_data[WIDTH-1:0] = replay ? rep_data : in_ch_data[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    case (state)
      LIVE:    state_n = fb & ~hs & in_capture_req ? CAPTURE : LIVE;
      CAPTURE: state_n = hs & ou_frame_last ? REPLAY : CAPTURE;
      REPLAY:  state_n = ~(fb & ~hs) ? REPLAY : in_release_req ? LIVE : in_capture_req ? CAPTURE : REPLAY;
      default: state_n = LIVE;
    endcase
  end
  always_ff @(posedge in_destination_clock or posedge reset_counter) begin
    if (reset_counter) begin
      state <= LIVE;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      if (hs) beat_cnt <= ou_frame_last ? '0 : beat_cnt + 1'b1;
    end
  end
  always_ff @(posedge in_destination_clock)
    if (state == CAPTURE && hs) mem[beat_cnt] <= in_ch_data[WIDTH-1:0];
  // prefetch the next cache word so the ch0 slot never bubbles
  always_ff @(posedge in_destination_clock or posedge reset_counter) begin
    if (reset_counter) rep_data <= '0;
    else if (hs && (replay || (state == CAPTURE && ou_frame_last))) rep_data <= mem[rd_addr];
  end
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
  always_ff @(posedge in_destination_clock or posedge reset_counter) begin
    if (reset_counter) begin
      ou_frames_done <= '0;
      ou_stall <= '0;
    end else begin
      if (hs && ou_frame_last) ou_frames_done <= ou_frames_done + 1'b1;
      ou_stall <= ou_frame_valid & ~in_frame_ready;
    end
  end
`endif
endmodule

// File: tb/tb_multi_frame_aligner.sv
// tb_multi_frame_aligner: randomized frame-level scoreboard bench for multi_frame_aligner
module tb_multi_frame_aligner;
  localparam int W = 16, N = 2, FL = 4, NF = 40;
  localparam int LIVE_M = 0, CAP_M = 1, REP_M = 2;
  typedef struct packed {logic [N*W-1:0] data; logic last; logic rl;} exp_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] v, rdy;
  logic [N*W-1:0] d, fd;
  logic cap, rel, fr, fv, fl, rl;
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
  logic [15:0] done;
  logic [0:0] stall;
`endif
  exp_t exp_q[$];
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] cache[FL];
  int total = 0, bad = 0, mst = LIVE_M, cur_mode = LIVE_M, done_m = 0;
  logic prev_stall = 0;
  bit c_a[NF+1], r_a[NF+1], e_a[NF+1];

  multi_frame_aligner #(.WIDTH(W), .N_CH(N), .FRAME_LEN(FL)) dut (
    .in_destination_clock(clk), .reset_counter(rst), .in_ch_valid(v), .in_ch_data(d),
    .ou_ch_ready(rdy), .in_capture_req(cap), .in_release_req(rel), .in_frame_ready(fr),
    .ou_frame_valid(fv), .ou_frame_last(fl), .ou_frame_data(fd), .ou_ref_loaded(rl)
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
    , .ou_frames_done(done), .ou_stall(stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (fv && fr) begin
          if (exp_q.size() == 0) chk("unexpected_beat", fv && fr, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_data", fd, e.data);
            chk("beat_last", fl, e.last);
            chk("beat_ref_loaded", rl, e.rl);
          end
        end
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
        chk("frames_done", done, 16'(done_m));
        chk("stall", stall, prev_stall);
        if (fv && fr && fl) done_m++;
        prev_stall = fv & ~fr;
`endif
      end
    end
  end

  task automatic step(input bit hold, input int fb, output bit beat);
    bit p0, p1;
    @(negedge clk);
    cap = (hold && fb >= 2) || (fb >= 1 && $urandom_range(7) == 0);
    rel = fb >= 1 && $urandom_range(7) == 0;
    v[0] = q0.size() > 0 ? ($urandom_range(3) != 0) : (cur_mode == REP_M && $urandom_range(1) == 1);
    d[W-1:0] = q0.size() > 0 ? q0[0] : W'($urandom);
    v[1] = q1.size() > 0 && $urandom_range(3) != 0;
    d[2*W-1:W] = q1.size() > 0 ? q1[0] : W'($urandom);
    fr = $urandom_range(3) != 0;
    #1;
    p0 = v[0] && rdy[0];
    p1 = v[1] && rdy[1];
    beat = fv && fr;
    chk("solo_pop", (p0 | p1) & ~beat, 0);
    chk("ch0_ready_in_replay", (cur_mode == REP_M) & rdy[0], 0);
    if (beat) chk("joint_pop", {p0, p1}, {cur_mode != REP_M, 1'b1});
    @(posedge clk);
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic run_frame(input bit c, input bit r, input bit hold, input int nb);
    logic [W-1:0] w0, w1;
    int fb = 0, budget = 0;
    bit beat;
    if (mst == LIVE_M) cur_mode = c ? CAP_M : LIVE_M;
    else cur_mode = r ? LIVE_M : c ? CAP_M : REP_M;
    mst = cur_mode == CAP_M ? REP_M : cur_mode;
    for (int k = 0; k < FL; k++) begin
      w0 = W'($urandom);
      w1 = W'($urandom);
      q1.push_back(w1);
      if (cur_mode == REP_M) w0 = cache[k];
      else q0.push_back(w0);
      if (cur_mode == CAP_M) cache[k] = w0;
      exp_q.push_back({{w1, w0}, k == FL - 1, cur_mode == REP_M});
    end
    @(negedge clk);
    v = '0;
    cap = c;
    rel = r;
    fr = $urandom_range(1) == 1;
    while (fb < nb && budget < 200) begin
      step(hold, fb, beat);
      fb += int'(beat);
      budget++;
    end
    if (fb < nb) chk("frame_timeout", fb, nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    v = '0; d = '0; cap = 0; rel = 0; fr = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_last", fl, 0);
    chk("rst_ref_loaded", rl, 0);
    chk("rst_valid_idle", fv, 0);
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
    chk("rst_frames_done", done, 0);
    chk("rst_stall", stall, 0);
`endif
    v = '1;
    #1;
    chk("rst_valid_all", fv, 1);
    v = '0;
    @(negedge clk);
    rst = 0;
    for (int f = 0; f <= NF; f++) begin
      c_a[f] = $urandom_range(2) == 0;
      r_a[f] = $urandom_range(2) == 0;
      e_a[f] = $urandom_range(1) == 1;
    end
    c_a[0] = 0; r_a[0] = 0;
    c_a[1] = 1; r_a[1] = 0; e_a[1] = 1;
    c_a[2] = 0; r_a[2] = 0;
    c_a[3] = 1; r_a[3] = 1; e_a[3] = 0;
    c_a[NF] = 1; e_a[NF] = 1;
    for (int f = 0; f < NF; f++) run_frame(c_a[f], r_a[f], c_a[f+1] && e_a[f+1], FL);
    run_frame(1, 0, 0, FL);
    run_frame(0, 0, 0, 2);
    @(negedge clk);
    v = '0;
    fr = 1;
    #3;
    rst = 1;
    #1;
    chk("mid_rst_last", fl, 0);
    chk("mid_rst_ref_loaded", rl, 0);
`ifdef MULTI_FRAME_ALIGNER_STATS_EN
    chk("mid_rst_frames_done", done, 0);
`endif
    exp_q.delete();
    q0.delete();
    q1.delete();
    mst = LIVE_M;
    cur_mode = LIVE_M;
    done_m = 0;
    prev_stall = 0;
    rst = 0;
    run_frame(0, 0, 0, FL);
    run_frame(1, 0, 0, FL);
    run_frame(0, 0, 0, FL);
    run_frame(1, 1, 0, FL);
    run_frame(0, 0, 0, FL);
    @(negedge clk);
    v = '0;
    cap = 0;
    rel = 0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("sources_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
